// File: rtl/enc_arb_ctrl.sv
// Round-robin front end for the shared codeword encoder: arbitrates two info-word
// sources, drives the encoder from hold registers and presents the tagged codeword.
module enc_arb_ctrl #(
  parameter int MAX_INFO_WIDTH     = 26,
  parameter int MAX_CODEWORD_WIDTH = 32,
  parameter int ENC_LATENCY        = 1,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid_a,
  input  logic                          req_valid_b,
  input  logic [MAX_INFO_WIDTH-1:0]     req_data_a,
  input  logic [MAX_INFO_WIDTH-1:0]     req_data_b,
  input  logic [1:0]                    req_mod_a,
  input  logic [1:0]                    req_mod_b,
  output logic                          req_ready_a,
  output logic                          req_ready_b,
  output logic [MAX_INFO_WIDTH-1:0]     enc_data_in,
  output logic [1:0]                    enc_mod,
  input  logic [MAX_CODEWORD_WIDTH-1:0] enc_data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] out_data,
  output logic                          out_id,
  output logic                          err_illegal_mod,
  output logic [CNT_WIDTH-1:0]          cw_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ENC_LATENCY);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                          state_r;
  logic [2:0]                      lat_cnt_r;
  logic                            last_grant_r;
  logic [MAX_INFO_WIDTH-1:0]       hold_data_r;
  logic [1:0]                      hold_mod_r;
  logic                            hold_id_r;
  logic [MAX_CODEWORD_WIDTH-1:0]   out_data_r;
  logic                            out_id_r;
  logic                            out_valid_r;
  logic                            err_r;
  logic [CNT_WIDTH-1:0]            cw_count_r;

  logic                            grant_valid_s;
  logic                            grant_id_s;
  logic                            accept_s;
  logic [MAX_INFO_WIDTH-1:0]       acc_data_s;
  logic [1:0]                      acc_mod_s;

  // Arbitration: a lone requester wins, a tie goes to the source not granted last.
  always_comb begin
    grant_valid_s = req_valid_a | req_valid_b;
    if (req_valid_a && req_valid_b) begin
      grant_id_s = ~last_grant_r;
    end else if (req_valid_b) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  assign accept_s    = (state_r == IDLE) & grant_valid_s;
  assign req_ready_a = accept_s & ~grant_id_s;
  assign req_ready_b = accept_s & grant_id_s;
  assign acc_data_s  = grant_id_s ? req_data_b : req_data_a;
  assign acc_mod_s   = grant_id_s ? req_mod_b : req_mod_a;

  // Control FSM with hold, output and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      lat_cnt_r    <= 3'd0;
      last_grant_r <= 1'b1;
      hold_data_r  <= '0;
      hold_mod_r   <= 2'b00;
      hold_id_r    <= 1'b0;
      out_data_r   <= '0;
      out_id_r     <= 1'b0;
      out_valid_r  <= 1'b0;
      err_r        <= 1'b0;
      cw_count_r   <= '0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            last_grant_r <= grant_id_s;
            // Mode 11 is consumed and flagged; the encoder keeps its previous word.
            if (acc_mod_s == 2'b11) begin
              err_r <= 1'b1;
            end else begin
              hold_data_r <= acc_data_s;
              hold_mod_r  <= acc_mod_s;
              hold_id_r   <= grant_id_s;
              lat_cnt_r   <= LAT_LOAD;
              state_r     <= BUSY;
            end
          end
        end
        BUSY: begin
          if (lat_cnt_r == 3'd0) begin
            out_data_r  <= enc_data_out;
            out_id_r    <= hold_id_r;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            cw_count_r  <= cw_count_r + CNT_ONE;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign enc_data_in     = hold_data_r;
  assign enc_mod         = hold_mod_r;
  assign out_valid       = out_valid_r;
  assign out_data        = out_data_r;
  assign out_id          = out_id_r;
  assign err_illegal_mod = err_r;
  assign cw_count        = cw_count_r;

endmodule

// File: tb/tb_enc_arb_ctrl.sv
// Directed bench for enc_arb_ctrl with a behavioural one-stage encoder and an
// output scoreboard fed at acceptance time.
module tb_enc_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic [25:0] req_data_a = 26'h0, req_data_b = 26'h0;
  logic [1:0]  req_mod_a = 2'b00, req_mod_b = 2'b00;
  logic        req_ready_a, req_ready_b;
  logic [25:0] enc_data_in;
  logic [1:0]  enc_mod;
  logic [31:0] enc_data_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_id;
  logic        err_illegal_mod;
  logic [3:0]  cw_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [32:0] sb[$];
  logic        grants[$];
  int          acc_cyc[$];
  logic [3:0]  exp_cnt = 4'd0;
  logic [31:0] enc_q = 32'h0;

  enc_arb_ctrl #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
    .req_data_a(req_data_a), .req_data_b(req_data_b),
    .req_mod_a(req_mod_a), .req_mod_b(req_mod_b),
    .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
    .enc_data_in(enc_data_in), .enc_mod(enc_mod), .enc_data_out(enc_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .err_illegal_mod(err_illegal_mod), .cw_count(cw_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_fn(input logic [25:0] d, input logic [1:0] m);
    logic [3:0]  n;
    logic [10:0] w;
    logic [31:0] r;
    n = d[3:0];
    w = d[10:0];
    case (m)
      2'b00:   r = {24'h0, n, ^n, n[0]^n[1]^n[3], n[0]^n[2]^n[3], n[1]^n[2]^n[3]};
      2'b01:   r = {16'h0, w, ^w, ^(w & 11'h56D), ^(w & 11'h59B), ^(w & 11'h71E), ^(w & 11'h7E0)};
      2'b10:   r = {d, ^d, ^(d & 26'h2AAAAAA), ^(d & 26'h1555555), ^(d & 26'h3333333),
                    ^(d & 26'h0F0F0F0), ^(d & 26'h3FF00FF)};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Behavioural encoder: one register stage.
  always @(posedge clk) enc_q <= enc_fn(enc_data_in, enc_mod);
  assign enc_data_out = enc_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
  endtask

  // Scoreboard: push at acceptance, pop and compare at output handshake.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      sb.delete();
      exp_cnt = 4'd0;
    end else begin
      if (req_ready_a || req_ready_b)
        chk("one_hot_ready", 32'(req_ready_a & req_ready_b), 32'd0);
      if (req_valid_a && req_ready_a) begin
        grants.push_back(1'b0);
        acc_cyc.push_back(cyc);
        if (req_mod_a != 2'b11) sb.push_back({1'b0, enc_fn(req_data_a, req_mod_a)});
      end
      if (req_valid_b && req_ready_b) begin
        grants.push_back(1'b1);
        acc_cyc.push_back(cyc);
        if (req_mod_b != 2'b11) sb.push_back({1'b1, enc_fn(req_data_b, req_mod_b)});
      end
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_data", out_data, e[31:0]);
          chk("out_id", 32'(out_id), 32'(e[32]));
        end
        chk("cw_count_pre", 32'(cw_count), 32'(exp_cnt));
        exp_cnt = exp_cnt + 4'd1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap;
    logic [3:0]  cnt_before;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cw_count", 32'(cw_count), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("idle_readies", 32'({req_ready_a, req_ready_b, out_valid, err_illegal_mod}), 32'd0);

    // Single word from A, default latency
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_data_a = 26'h000000A; req_mod_a = 2'b00;
    @(negedge clk);
    chk("single_ready_ab", 32'({req_ready_a, req_ready_b}), 32'd2);
    @(posedge clk); #1 req_valid_a = 1'b0;
    @(negedge clk);
    chk("single_busy0", 32'(out_valid), 32'd0);
    chk("single_enc_in", 32'({enc_mod, enc_data_in}), 32'h000000A);
    @(negedge clk);
    chk("single_busy1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'h000000A2);
    chk("single_id", 32'(out_id), 32'd0);
    @(negedge clk);
    chk("single_drop", 32'(out_valid), 32'd0);
    chk("single_count", 32'(cw_count), 32'd1);

    // Backpressure on a B word
    @(posedge clk); #1;
    out_ready = 1'b0;
    req_valid_b = 1'b1; req_data_b = 26'h3FFFFFF; req_mod_b = 2'b10;
    @(posedge clk); #1 req_valid_b = 1'b0;
    wait_out(10);
    snap = out_data;
    chk("bp_data", snap, 32'hFFFFFFC0 | enc_fn(26'h3FFFFFF, 2'b10));
    chk("bp_id", 32'(out_id), 32'd1);
    @(posedge clk); #1;
    req_valid_b = 1'b1; req_data_b = 26'h00007FF; req_mod_b = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_flags", 32'({out_valid, req_ready_a, req_ready_b}), 32'd4);
      chk("bp_hold_data", out_data, snap);
    end
    cnt_before = cw_count;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_count_inc", 32'(cw_count), 32'(cnt_before + 4'd1));
    chk("bp_valid_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1 req_valid_b = 1'b0;
    wait_out(10);
    repeat (2) @(negedge clk);

    // Fairness with both sources valid
    grants.delete();
    acc_cyc.delete();
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_data_a = 26'h0000005; req_mod_a = 2'b01;
    req_valid_b = 1'b1; req_data_b = 26'h1234567; req_mod_b = 2'b10;
    n = 0;
    while (grants.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1 req_valid_a = 1'b0; req_valid_b = 1'b0;
    chk("fair_grant_count", 32'(grants.size() >= 4), 32'd1);
    if (grants.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("fair_order", 32'(grants[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) chk("fair_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    end
    repeat (8) @(negedge clk);
    chk("fair_drained", 32'(sb.size()), 32'd0);

    // Illegal mode from A, then B wins the tie
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_data_a = 26'h0000BAD; req_mod_a = 2'b11;
    @(negedge clk);
    chk("ill_ready_a", 32'(req_ready_a), 32'd1);
    cnt_before = cw_count;
    @(posedge clk); #1;
    req_data_a = 26'h0000003; req_mod_a = 2'b00;
    req_valid_b = 1'b1; req_data_b = 26'h0000123; req_mod_b = 2'b01;
    @(negedge clk);
    chk("ill_err_pulse", 32'({err_illegal_mod, out_valid}), 32'd2);
    chk("ill_next_grant_b", 32'({req_ready_a, req_ready_b}), 32'd1);
    @(posedge clk); #1 req_valid_a = 1'b0; req_valid_b = 1'b0;
    @(negedge clk);
    chk("ill_err_clear", 32'(err_illegal_mod), 32'd0);
    chk("ill_count_same", 32'(cw_count), 32'(cnt_before));
    wait_out(10);
    chk("ill_b_id", 32'(out_id), 32'd1);
    repeat (2) @(negedge clk);

    // Asynchronous reset while BUSY
    @(posedge clk); #1;
    req_valid_a = 1'b1; req_data_a = 26'h0000007; req_mod_a = 2'b00;
    @(posedge clk); #1 req_valid_a = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_outs", 32'({out_valid, out_id, err_illegal_mod, req_ready_a, req_ready_b}), 32'd0);
    chk("arst_data", out_data, 32'd0);
    chk("arst_count", 32'(cw_count), 32'd0);
    chk("arst_enc", 32'({enc_mod, enc_data_in}), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_output", 32'(out_valid), 32'd0);
    end

    // Counter wrap with a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      req_valid_a = 1'b1; req_data_a = 26'(i * 37 + 1); req_mod_a = 2'(i % 3);
      @(posedge clk); #1 req_valid_a = 1'b0;
      wait_out(10);
    end
    @(negedge clk);
    chk("wrap_count", 32'(cw_count), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enc_arb_ctrl.md
# enc_arb_ctrl

Two-requester round-robin controller that shares the single registered encoder stage (modes 00/01/10 → 8/16/32-bit codewords) between two info-word sources. Accepts one info word at a time over a valid/ready handshake, drives the encoder's `data_in`/`mod` from hold registers, waits out the encoder latency, and captures the codeword. Presents the codeword with a source tag under valid/ready backpressure. Sits between the upstream info-word producers and the downstream codeword consumer.

## Interface
- `MAX_INFO_WIDTH`, 26, info word width; matches the encoder input.
- `MAX_CODEWORD_WIDTH`, 32, codeword width; matches the encoder output.
- `ENC_LATENCY`, 1, encoder register stages between its input and `data_out`; legal range 1–7.
- `CNT_WIDTH`, 16, width of the completed-codeword counter.

Ports:
- `clk` input 1 — single clock; all logic on posedge.
- `rst` input 1 — asynchronous, active-low reset.
- `req_valid_a`, `req_valid_b` input 1 — a source presents a word.
- `req_data_a`, `req_data_b` input MAX_INFO_WIDTH — info word, LSB-aligned.
- `req_mod_a`, `req_mod_b` input 2 — encoding mode.
- `req_ready_a`, `req_ready_b` output 1 — word accepted on valid&ready.
- `enc_data_in` output MAX_INFO_WIDTH — to encoder `data_in`.
- `enc_mod` output 2 — to encoder `mod`.
- `enc_data_out` input MAX_CODEWORD_WIDTH — from encoder.
- `out_valid` output 1 — codeword available.
- `out_ready` input 1 — downstream accepts.
- `out_data` output MAX_CODEWORD_WIDTH — captured codeword.
- `out_id` output 1 — source of the codeword: 0 = A, 1 = B.
- `err_illegal_mod` output 1 — one-cycle pulse when a word with mod 2'b11 is accepted.
- `cw_count` output CNT_WIDTH — count of completed output handshakes; wraps.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE arbitration:**
  - Only A valid → grant A; only B valid → grant B.
  - Both valid → grant the source not granted last (`last_grant`).
  - `req_ready_x` = (state==IDLE) & grant==x, combinational. At most one ready high.
- **Accept with legal mod:**
  - Latch data, mod and id into hold registers; update `last_grant`.
  - Load the counter with ENC_LATENCY; go to BUSY.
- **Accept with mod 2'b11:**
  - Word is consumed and dropped; `last_grant` is updated.
  - `err_illegal_mod` is registered high for the next cycle; state stays IDLE.
  - Hold registers and the encoder are not touched.
- **Encoder drive:** `enc_data_in`/`enc_mod` come directly from the hold registers and stay stable from acceptance until the next acceptance.
- **BUSY:**
  - Counter decrements each cycle.
  - When counter==0, the edge captures `enc_data_out` into `out_data`, sets `out_valid`, and moves to DONE.
- **DONE:**
  - `out_valid`=1; `out_data`/`out_id` are held stable.
  - On `out_valid & out_ready`: `out_valid`←0, `cw_count`←`cw_count`+1 (wraps at 2^CNT_WIDTH), go to IDLE.
  - No acceptance occurs in the same cycle.
- **Reset (async, any time):**
  - State←IDLE, `last_grant`←1 (A wins the first tie).
  - Hold registers, `out_data`, `out_id`, `out_valid`, `err_illegal_mod`, `cw_count` ← 0.
  - Any in-flight word is lost; no output or error is produced for it.

## Timing
- Accept at edge E0 → `out_valid` high after edge E0+ENC_LATENCY+1. BUSY lasts ENC_LATENCY+1 cycles.
- With `out_ready` tied high: DONE lasts 1 cycle and IDLE 1 cycle, so throughput is one word per ENC_LATENCY+3 cycles (4 at default).
- Requests are sampled only in IDLE. `req_valid` deasserting outside IDLE has no effect.
- `out_ready` low holds DONE indefinitely. Requests stall; `req_ready` stays 0.
- `err_illegal_mod` asserts the cycle after acceptance, for exactly 1 cycle. Back-to-back illegal words give one pulse per word.
- Mode change between words requires no flush: the encoder sees the new mod together with the new data.

## Test plan
- **Reset values:** drive `rst`=0 mid-BUSY → all outputs 0 immediately (asynchronously). After release with no valids: `req_ready_a`=`req_ready_b`=0, `out_valid`=0.
- **Single word, A, default latency:** `req_data_a`=26'h000000A, mod 00, accepted at E0 → `out_valid` after E2; `out_data[31:8]`=0, `out_data[7:4]`=4'hA, bits [3:0] equal to the golden parity; `out_id`=0; `cw_count`=1 after the handshake.
- **Fairness:** A and B both valid continuously, `out_ready`=1 → grant order A, B, A, B; `out_id` sequence 0,1,0,1; accepts spaced 4 cycles apart.
- **Backpressure:** B, mod 10, data 26'h3FFFFFF; hold `out_ready`=0 for 10 cycles → `out_valid` and `out_data` stay stable, both `req_ready` stay 0; release → one handshake, `cw_count` increments by exactly 1.
- **Illegal mod:** A with mod 11 → `req_ready_a`=1 for 1 cycle, `err_illegal_mod`=1 for 1 cycle, no `out_valid`, `cw_count` unchanged; a subsequent B request is granted next.
- **Counter wrap:** with CNT_WIDTH=4, complete 17 words → `cw_count`=1.
